// File: rtl/led_share_arbiter.sv
// Round-robin owner arbitration for the shared LED bank, with a minimum hold time.
// The registered LED mux shows the owner's pattern, or the DIP switches when the bank is idle.
module led_share_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int LED_W       = 16,
  parameter int HOLD_CYCLES = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*LED_W-1:0] data,
  input  logic [LED_W-1:0]         switch,
  output logic [NUM_REQ-1:0]       grant,
  output logic [LED_W-1:0]         led,
  output logic                     busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic {IDLE, OWN} state_t;

  state_t               state;
  logic [IW-1:0]        ptr;
  logic [CW-1:0]        cnt;
  logic [NUM_REQ-1:0]   cand;
  logic [IW-1:0]        win;
  logic                 any;
  logic                 sat;
  logic [LED_W-1:0]     slice [NUM_REQ];

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      slice[i] = data[i*LED_W +: LED_W];
    end
  end

  // ptr always equals the current owner while in OWN, so masking the grant
  // makes the owner lowest priority in both handover and preemption.
  assign cand = (state == OWN) ? (req & ~grant) : req;
  assign sat  = (cnt == CW'(HOLD_CYCLES - 1));

  // Search upward from ptr+1 with wrap: indices above ptr first, then the rest.
  always_comb begin
    logic          hi_found;
    logic          lo_found;
    logic [IW-1:0] hi_win;
    logic [IW-1:0] lo_win;
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_win   = '0;
    lo_win   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (cand[i]) begin
        if (i > 32'(ptr)) begin
          if (!hi_found) begin
            hi_found = 1'b1;
            hi_win   = IW'(i);
          end
        end else if (!lo_found) begin
          lo_found = 1'b1;
          lo_win   = IW'(i);
        end
      end
    end
    any = hi_found | lo_found;
    win = hi_found ? hi_win : lo_win;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      led   <= '0;
      busy  <= 1'b0;
      cnt   <= '0;
      ptr   <= IW'(NUM_REQ - 1);
    end else begin
      led <= (grant != '0) ? slice[ptr] : switch;
      case (state)
        IDLE: begin
          if (any) begin
            state <= OWN;
            grant <= NUM_REQ'(1) << win;
            ptr   <= win;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        OWN: begin
          if (!req[ptr] || (sat && any)) begin
            if (any) begin
              grant <= NUM_REQ'(1) << win;
              ptr   <= win;
              cnt   <= '0;
            end else begin
              state <= IDLE;
              grant <= '0;
              busy  <= 1'b0;
              cnt   <= '0;
            end
          end else if (!sat) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_share_arbiter.sv
// Bench for led_share_arbiter: directed vector table, hand-written hold/preempt sequences,
// and randomized traffic against an index/modulo reference model of the ownership rules.
module tb_led_share_arbiter;
  localparam int N = 4;
  localparam int W = 16;
  localparam int H = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     req = '0;
  logic [N*W-1:0]   data = '0;
  logic [W-1:0]     switch = '0;
  logic [N-1:0]     grant;
  logic [W-1:0]     led;
  logic             busy;

  always #5 clk = ~clk;

  led_share_arbiter #(.NUM_REQ(N), .LED_W(W), .HOLD_CYCLES(H)) dut (
    .clk(clk), .rst(rst), .req(req), .data(data), .switch(switch),
    .grant(grant), .led(led), .busy(busy)
  );

  int passed = 0;
  int total  = 0;

  int           m_owner = -1;
  int           m_ptr   = N - 1;
  int           m_cnt   = 0;
  logic [W-1:0] m_led   = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic int pick(input logic [N-1:0] q, input int from, input int excl);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (from + k) % N;
      if (idx != excl && q[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_update(input logic r, input logic [N-1:0] q,
                              input logic [N*W-1:0] d, input logic [W-1:0] s);
    int w;
    if (r) begin
      m_owner = -1; m_ptr = N - 1; m_cnt = 0; m_led = '0;
    end else begin
      m_led = (m_owner >= 0) ? d[m_owner*W +: W] : s;
      if (m_owner < 0) begin
        w = pick(q, m_ptr, -1);
        if (w >= 0) begin m_owner = w; m_ptr = w; m_cnt = 0; end
      end else if (!q[m_owner]) begin
        w = pick(q, m_owner, m_owner);
        if (w >= 0) begin m_owner = w; m_ptr = w; end
        else m_owner = -1;
        m_cnt = 0;
      end else if (m_cnt >= H - 1) begin
        w = pick(q, m_owner, m_owner);
        if (w >= 0) begin m_owner = w; m_ptr = w; m_cnt = 0; end
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic step(input logic r, input logic [N-1:0] q,
                      input logic [N*W-1:0] d, input logic [W-1:0] s);
    logic [N-1:0] eg;
    rst = r; req = q; data = d; switch = s;
    @(posedge clk);
    model_update(r, q, d, s);
    #1;
    eg = (m_owner < 0) ? '0 : (N'(1) << m_owner);
    chk("model_grant", 32'(grant), 32'(eg));
    chk("model_led", 32'(led), 32'(m_led));
    chk("model_busy", 32'(busy), 32'(m_owner >= 0));
  endtask

  typedef struct {
    logic         r;
    logic [N-1:0] q;
    logic [W-1:0] s;
    logic [N-1:0] g;
    logic [W-1:0] l;
    logic         b;
  } vec_t;

  vec_t tbl [10];
  localparam logic [N*W-1:0] DFIX = {16'h4444, 16'h00FF, 16'h2222, 16'h1111};

  initial begin
    logic [N*W-1:0] rd;
    logic [N-1:0]   rq;
    logic [N-1:0]   eg;

    // idle passthrough, single grant/release, reset mid-ownership
    tbl[0] = '{1'b1, 4'b0000, 16'hA5C3, 4'b0000, 16'h0000, 1'b0};
    tbl[1] = '{1'b0, 4'b0000, 16'hA5C3, 4'b0000, 16'hA5C3, 1'b0};
    tbl[2] = '{1'b0, 4'b0100, 16'hA5C3, 4'b0100, 16'hA5C3, 1'b1};
    tbl[3] = '{1'b0, 4'b0100, 16'hA5C3, 4'b0100, 16'h00FF, 1'b1};
    tbl[4] = '{1'b0, 4'b0000, 16'hA5C3, 4'b0000, 16'h00FF, 1'b0};
    tbl[5] = '{1'b0, 4'b0000, 16'hA5C3, 4'b0000, 16'hA5C3, 1'b0};
    tbl[6] = '{1'b0, 4'b0010, 16'hA5C3, 4'b0010, 16'hA5C3, 1'b1};
    tbl[7] = '{1'b1, 4'b0010, 16'hA5C3, 4'b0000, 16'h0000, 1'b0};
    tbl[8] = '{1'b0, 4'b0011, 16'hA5C3, 4'b0001, 16'hA5C3, 1'b1};
    tbl[9] = '{1'b0, 4'b0011, 16'hA5C3, 4'b0001, 16'h1111, 1'b1};

    for (int i = 0; i < 10; i++) begin
      step(tbl[i].r, tbl[i].q, DFIX, tbl[i].s);
      chk("tbl_grant", 32'(grant), 32'(tbl[i].g));
      chk("tbl_led", 32'(led), 32'(tbl[i].l));
      chk("tbl_busy", 32'(busy), 32'(tbl[i].b));
    end

    // hold/preempt between two requesters
    step(1'b1, '0, DFIX, 16'h0F0F);
    for (int j = 0; j < 24; j++) begin
      step(1'b0, 4'b0011, DFIX, 16'h0F0F);
      eg = ((j / H) % 2 == 1) ? 4'b0010 : 4'b0001;
      chk("hold2_grant", 32'(grant), 32'(eg));
    end

    // fairness with all four requesting
    step(1'b1, '0, DFIX, 16'h0F0F);
    for (int j = 0; j < 64; j++) begin
      step(1'b0, 4'b1111, DFIX, 16'h0F0F);
      eg = N'(1) << ((j / H) % N);
      chk("rr_grant", 32'(grant), 32'(eg));
    end

    // early release at cnt=2 hands straight to requester 3, whose hold restarts
    step(1'b1, '0, DFIX, 16'h0F0F);
    step(1'b0, 4'b1010, DFIX, 16'h0F0F);
    chk("early_first", 32'(grant), 32'(4'b0010));
    step(1'b0, 4'b1010, DFIX, 16'h0F0F);
    step(1'b0, 4'b1010, DFIX, 16'h0F0F);
    chk("early_hold", 32'(grant), 32'(4'b0010));
    step(1'b0, 4'b1000, DFIX, 16'h0F0F);
    chk("early_handover", 32'(grant), 32'(4'b1000));
    for (int k = 0; k < H - 1; k++) begin
      step(1'b0, 4'b1011, DFIX, 16'h0F0F);
      chk("early_newhold", 32'(grant), 32'(4'b1000));
    end
    step(1'b0, 4'b1011, DFIX, 16'h0F0F);
    chk("early_preempt", 32'(grant), 32'(4'b0001));

    // randomized traffic with sticky requests and occasional reset
    rq = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(7) == 0) rq[b] = ~rq[b];
      end
      rd = {$urandom, $urandom};
      step(($urandom_range(199) == 0), rq, rd, W'($urandom));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
